msg_framer: RTL and testbench

MSG_FRAMER -- requirements
Module: msg_framer

---
 rtl/msg_framer.sv | 165 ++++++++++++++++
 tb/tb_msg_framer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_framer.sv
// msg_framer
// Packs a raw byte stream of length-prefixed messages into 32-bit big-endian
// words for a downstream parser.
//
// Message layout: bytes 0-1 total length L (big-endian, counts the 8 header
// bytes), bytes 2-3 stream id, bytes 4-7 sequence, bytes 8..L-1 payload.
// Legal L is 9..45. An illegal L latches lengthError and stops input until reset.
//
// Ports:
//   clk            rising-edge clock
//   reset_b        asynchronous active-low reset
//   byteIn[7:0]    raw byte stream
//   byteIn_val     byteIn valid
//   byteIn_ready   byte accepted this cycle when byteIn_val is also high
//   dataOut[31:0]  packed word, first byte in [31:24]
//   dataOut_val    dataOut valid
//   dataOut_ready  downstream accepts dataOut
//   dataOut_last   dataOut is the final word of a message
//   lengthError    sticky illegal-length flag
//   msgCount[15:0] count of messages fully accepted downstream
//
// Build option: define FRAMER_MSGCOUNT_EN to enable the msgCount counter;
// otherwise msgCount is tied to zero.

module msg_framer (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [7:0]  byteIn,
  input  logic        byteIn_val,
  output logic        byteIn_ready,
  output logic [31:0] dataOut,
  output logic        dataOut_val,
  input  logic        dataOut_ready,
  output logic        dataOut_last,
  output logic        lengthError,
  output logic [15:0] msgCount
);

  typedef enum logic [1:0] {HDR, BODY, ERR} state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] byte_cnt;
  logic [15:0] msg_len;
  logic [31:0] asm_word;

  logic        accept;
  logic        word_done;
  logic        final_byte;
  logic        len_legal;
  logic [15:0] hdr_len;
  logic [4:0]  shift;
  logic [31:0] merged;

  // Only registered signals and dataOut_ready feed the ready output.
  assign byteIn_ready = !lengthError && (!dataOut_val || dataOut_ready);
  assign accept       = byteIn_val && byteIn_ready;

  // Next-state and word-completion decode.
  always_comb begin
    next_state = state;
    word_done  = 1'b0;
    final_byte = 1'b0;
    hdr_len    = {msg_len[15:8], byteIn};
    len_legal  = (hdr_len >= 16'd9) && (hdr_len <= 16'd45);
    // Byte slot within the word: slot 0 lands in [31:24], slot 3 in [7:0].
    shift      = {~byte_cnt[1:0], 3'b000};
    merged     = asm_word | ({24'd0, byteIn} << shift);
    case (state)
      HDR: begin
        if (accept && byte_cnt[0]) begin
          next_state = len_legal ? BODY : ERR;
        end
      end
      BODY: begin
        if (accept) begin
          final_byte = (byte_cnt == msg_len - 16'd1);
          word_done  = final_byte || (byte_cnt[1:0] == 2'd3);
          if (final_byte) begin
            next_state = HDR;
          end
        end
      end
      ERR: begin
        next_state = ERR;
      end
      default: begin
        next_state = HDR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= HDR;
    end else begin
      state <= next_state;
    end
  end

  // Byte counter, length capture, word assembly and output register.
  // The completed word bypasses the assembly register straight into dataOut,
  // so the assembly register is cleared on that same edge.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      byte_cnt     <= 16'd0;
      msg_len      <= 16'd0;
      asm_word     <= 32'd0;
      dataOut      <= 32'd0;
      dataOut_val  <= 1'b0;
      dataOut_last <= 1'b0;
      lengthError  <= 1'b0;
    end else begin
      if (accept) begin
        if (state == HDR) begin
          if (byte_cnt[0]) begin
            msg_len <= hdr_len;
          end else begin
            msg_len[15:8] <= byteIn;
          end
        end
        if (final_byte) begin
          byte_cnt <= 16'd0;
          asm_word <= 32'd0;
        end else if (word_done) begin
          byte_cnt <= byte_cnt + 16'd1;
          asm_word <= 32'd0;
        end else begin
          byte_cnt <= byte_cnt + 16'd1;
          asm_word <= merged;
        end
      end

      if (accept && word_done) begin
        dataOut      <= merged;
        dataOut_val  <= 1'b1;
        dataOut_last <= final_byte;
      end else if (dataOut_ready) begin
        dataOut_val  <= 1'b0;
      end

      if (next_state == ERR) begin
        lengthError <= 1'b1;
      end
    end
  end

`ifdef FRAMER_MSGCOUNT_EN
  logic [15:0] msg_count_q;

  // Counts final words as they leave, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      msg_count_q <= 16'd0;
    end else if (dataOut_val && dataOut_ready && dataOut_last) begin
      msg_count_q <= msg_count_q + 16'd1;
    end
  end

  assign msgCount = msg_count_q;
`else
  assign msgCount = 16'd0;
`endif

endmodule

// File: tb/tb_msg_framer.sv
// tb_msg_framer
// Self-checking bench for msg_framer. Messages are generated with random
// contents and the expected word stream is computed by chunking each message
// into groups of four bytes with zero fill. Honours FRAMER_MSGCOUNT_EN when
// predicting msgCount.

module tb_msg_framer;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic [7:0]  byteIn = 8'd0;
  logic        byteIn_val = 1'b0;
  logic        byteIn_ready;
  logic [31:0] dataOut;
  logic        dataOut_val;
  logic        dataOut_ready = 1'b0;
  logic        dataOut_last;
  logic        lengthError;
  logic [15:0] msgCount;

  int checks = 0;
  int fails = 0;
  int exp_msgs = 0;
  int hold_viol = 0;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic        prev_last = 1'b0;

  msg_framer dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .byteIn        (byteIn),
    .byteIn_val    (byteIn_val),
    .byteIn_ready  (byteIn_ready),
    .dataOut       (dataOut),
    .dataOut_val   (dataOut_val),
    .dataOut_ready (dataOut_ready),
    .dataOut_last  (dataOut_last),
    .lengthError   (lengthError),
    .msgCount      (msgCount)
  );

  always #5 clk = ~clk;

  // Records every word handed downstream and notes any change of a stalled word.
  always @(negedge clk) begin
    if (reset_b && dataOut_val && dataOut_ready) got_q.push_back({dataOut_last, dataOut});
    if (prev_stall && (!dataOut_val || dataOut !== prev_data || dataOut_last !== prev_last))
      hold_viol++;
    prev_stall = reset_b && dataOut_val && !dataOut_ready;
    prev_data  = dataOut;
    prev_last  = dataOut_last;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] exp_count();
`ifdef FRAMER_MSGCOUNT_EN
    return exp_msgs[15:0];
`else
    return 16'd0;
`endif
  endfunction

  task automatic do_reset();
    byteIn_val    = 1'b0;
    byteIn        = 8'd0;
    dataOut_ready = 1'b0;
    @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    got_q.delete();
    exp_q.delete();
    exp_msgs = 0;
  endtask

  task automatic make_msg(input int len, output logic [7:0] m[$]);
    m.delete();
    m.push_back(len[15:8]);
    m.push_back(len[7:0]);
    for (int i = 2; i < len; i++) m.push_back(8'($urandom_range(255)));
  endtask

  // Expected words: consecutive 4-byte chunks, short tail zero-filled.
  task automatic model_msg(input logic [7:0] m[$]);
    logic [31:0] w;
    int n;
    n = m.size();
    for (int base = 0; base < n; base += 4) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++)
        if (base + k < n) w[31 - 8*k -: 8] = m[base + k];
      exp_q.push_back({(base + 4 >= n), w});
    end
    exp_msgs++;
  endtask

  task automatic drive(input logic [7:0] s[$], input int gap_pct, input int rdy_pct,
                       input int max_cyc, output bit timed_out, output int stalls);
    int idx;
    int cyc;
    bit acc;
    idx = 0; cyc = 0; stalls = 0; timed_out = 1'b0;
    forever begin
      @(posedge clk); #1;
      dataOut_ready = (int'($urandom_range(99)) < rdy_pct);
      if (idx < s.size()) begin
        byteIn     = s[idx];
        byteIn_val = (int'($urandom_range(99)) >= gap_pct);
      end else begin
        byteIn_val = 1'b0;
      end
      @(negedge clk);
      acc = byteIn_val && byteIn_ready;
      if (byteIn_val && !byteIn_ready) stalls++;
      if (acc) idx++;
      cyc++;
      if (idx == s.size() && !acc && !dataOut_val) break;
      if (cyc >= max_cyc) begin
        timed_out = 1'b1;
        break;
      end
    end
    byteIn_val = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (byteIn_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset byteIn_ready: got %b expected 1", byteIn_ready); end
    checks++; if (dataOut_val !== 1'b0) begin fails++; $display("[TB] FAIL reset dataOut_val: got %b expected 0", dataOut_val); end
    checks++; if (dataOut !== 32'd0) begin fails++; $display("[TB] FAIL reset dataOut: got %h expected 0", dataOut); end
    checks++; if (dataOut_last !== 1'b0) begin fails++; $display("[TB] FAIL reset dataOut_last: got %b expected 0", dataOut_last); end
    checks++; if (lengthError !== 1'b0) begin fails++; $display("[TB] FAIL reset lengthError: got %b expected 0", lengthError); end
    checks++; if (msgCount !== 16'd0) begin fails++; $display("[TB] FAIL reset msgCount: got %h expected 0", msgCount); end
  endtask

  task automatic test_basic_packing();
    logic [7:0] m[$];
    bit to;
    int st;
    do_reset();
    m = '{8'h00, 8'h09, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'hAB};
    exp_q = '{{1'b0, 32'h00090005}, {1'b0, 32'h00000007}, {1'b1, 32'hAB000000}};
    exp_msgs = 1;
    drive(m, 0, 100, 200, to, st);
    checks++; if (to) begin fails++; $display("[TB] FAIL basic timeout: got 1 expected 0"); end
    checks++; if (got_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL basic word count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL basic word %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (msgCount !== exp_count()) begin fails++; $display("[TB] FAIL basic msgCount: got %0d expected %0d", msgCount, exp_count()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m[$];
    logic [7:0] m2[$];
    bit to;
    int st;
    do_reset();
    m = '{8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'hBE, 8'hEF};
    model_msg(m);
    make_msg(9, m2);
    model_msg(m2);
    foreach (m2[i]) m.push_back(m2[i]);
    drive(m, 0, 100, 200, to, st);
    checks++; if (to) begin fails++; $display("[TB] FAIL b2b timeout: got 1 expected 0"); end
    checks++; if (st != 0) begin fails++; $display("[TB] FAIL b2b stall cycles: got %0d expected 0", st); end
    checks++; if (got_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL b2b word count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL b2b word %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 2) begin
      checks++;
      if (got_q[2] !== {1'b1, 32'hCAFEBEEF}) begin fails++; $display("[TB] FAIL b2b final word: got %h expected 1cafebeef", got_q[2]); end
    end
    checks++; if (msgCount !== exp_count()) begin fails++; $display("[TB] FAIL b2b msgCount: got %0d expected %0d", msgCount, exp_count()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] m[$];
    logic [7:0] rest[$];
    bit to;
    int st;
    int idx;
    int guard;
    do_reset();
    m = '{8'h00, 8'h09, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'hAB};
    model_msg(m);
    idx = 0; guard = 0;
    while (idx < 4 && guard < 20) begin
      @(posedge clk); #1;
      dataOut_ready = 1'b0; byteIn_val = 1'b1; byteIn = m[idx];
      @(negedge clk);
      if (byteIn_ready) idx++;
      guard++;
    end
    checks++; if (idx != 4) begin fails++; $display("[TB] FAIL bp first word bytes: got %0d expected 4", idx); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      dataOut_ready = 1'b0; byteIn_val = 1'b1; byteIn = m[4];
      @(negedge clk);
      checks++; if (dataOut_val !== 1'b1) begin fails++; $display("[TB] FAIL bp hold val cycle %0d: got %b expected 1", c, dataOut_val); end
      checks++; if (dataOut !== 32'h00090005) begin fails++; $display("[TB] FAIL bp hold data cycle %0d: got %h expected 00090005", c, dataOut); end
      checks++; if (byteIn_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp ready cycle %0d: got %b expected 0", c, byteIn_ready); end
    end
    rest = m[4:$];
    drive(rest, 0, 100, 200, to, st);
    checks++; if (to) begin fails++; $display("[TB] FAIL bp timeout: got 1 expected 0"); end
    checks++; if (got_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL bp word count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL bp word %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_length_error();
    int bad[4] = '{8, 46, 265, 0};
    logic [7:0] hdr[2];
    int idx;
    int guard;
    foreach (bad[b]) begin
      do_reset();
      hdr[0] = bad[b][15:8];
      hdr[1] = bad[b][7:0];
      idx = 0; guard = 0;
      while (idx < 2 && guard < 20) begin
        @(posedge clk); #1;
        dataOut_ready = 1'b1; byteIn_val = 1'b1; byteIn = hdr[idx];
        @(negedge clk);
        if (byteIn_ready) idx++;
        guard++;
      end
      checks++; if (lengthError !== 1'b0) begin fails++; $display("[TB] FAIL lenerr early L=%0d: got %b expected 0", bad[b], lengthError); end
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        byteIn_val = 1'b1; byteIn = 8'h55;
        @(negedge clk);
        checks++; if (lengthError !== 1'b1) begin fails++; $display("[TB] FAIL lenerr flag L=%0d cycle %0d: got %b expected 1", bad[b], c, lengthError); end
        checks++; if (byteIn_ready !== 1'b0) begin fails++; $display("[TB] FAIL lenerr ready L=%0d cycle %0d: got %b expected 0", bad[b], c, byteIn_ready); end
      end
      do_reset();
      checks++; if (lengthError !== 1'b0) begin fails++; $display("[TB] FAIL lenerr clear L=%0d: got %b expected 0", bad[b], lengthError); end
      checks++; if (byteIn_ready !== 1'b1) begin fails++; $display("[TB] FAIL lenerr ready after reset L=%0d: got %b expected 1", bad[b], byteIn_ready); end
    end
  endtask

  task automatic test_reset_mid_message();
    logic [7:0] m[$];
    logic [7:0] part[$];
    bit to;
    int st;
    do_reset();
    make_msg(20, m);
    part = m[0:5];
    drive(part, 0, 100, 200, to, st);
    do_reset();
    make_msg(15, m);
    model_msg(m);
    drive(m, 20, 70, 500, to, st);
    checks++; if (to) begin fails++; $display("[TB] FAIL midreset timeout: got 1 expected 0"); end
    checks++; if (got_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL midreset word count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL midreset word %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (msgCount !== exp_count()) begin fails++; $display("[TB] FAIL midreset msgCount: got %0d expected %0d", msgCount, exp_count()); end
  endtask

  task automatic test_random_stream();
    logic [7:0] m[$];
    logic [7:0] s[$];
    bit to;
    int st;
    int len;
    int hv0;
    do_reset();
    hv0 = hold_viol;
    s.delete();
    for (int n = 0; n < 12; n++) begin
      len = (n == 0) ? 9 : (n == 1) ? 45 : int'($urandom_range(45, 9));
      make_msg(len, m);
      model_msg(m);
      foreach (m[i]) s.push_back(m[i]);
    end
    drive(s, 30, 60, 5000, to, st);
    checks++; if (to) begin fails++; $display("[TB] FAIL random timeout: got 1 expected 0"); end
    checks++; if (got_q.size() != exp_q.size()) begin fails++; $display("[TB] FAIL random word count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("[TB] FAIL random word %0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (hold_viol != hv0) begin fails++; $display("[TB] FAIL random stall stability: got %0d changes expected 0", hold_viol - hv0); end
    checks++; if (lengthError !== 1'b0) begin fails++; $display("[TB] FAIL random lengthError: got %b expected 0", lengthError); end
    checks++; if (msgCount !== exp_count()) begin fails++; $display("[TB] FAIL random msgCount: got %0d expected %0d", msgCount, exp_count()); end
  endtask

  initial begin
    test_reset();
    test_basic_packing();
    test_back_to_back();
    test_backpressure();
    test_length_error();
    test_reset_mid_message();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
